// File: rtl/rom_operand_fetch.sv
// rom_operand_fetch
//
// Sequencer between the 16x32 constant ROM and the ALU. After one start
// pulse it fetches a programmable number of operand pairs (A from one address
// stream, B from another), presenting each pair to the ALU with a
// valid/ready handshake.
//
// Optional feature: define ROM_FETCH_STRIDE_EN to add the stride_i port.
// When it is defined, both pointers advance by a stride latched at start.
// When it is undefined, the port is absent and the pointers advance by 1.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   start_i     begin a run (sampled only in IDLE)
//   addr_a_i    first ROM address of the A stream
//   addr_b_i    first ROM address of the B stream
//   count_i     pairs to fetch, 0 means 2**AW
//   stride_i    pointer step per pair (ROM_FETCH_STRIDE_EN only)
//   rom_dir_o   ROM address (combinational ROM, data returns same cycle)
//   rom_dato_i  ROM read data
//   op_a_o      registered operand A
//   op_b_o      registered operand B
//   valid_o     op_a_o/op_b_o hold a valid pair
//   ready_i     ALU accepts the pair
//   busy_o      high whenever not IDLE
//   done_o      one-cycle pulse after the last pair is accepted
//
// state   | meaning
// IDLE    | waiting for start_i, ROM address parked at 0
// FETCH_A | reading A operand at ptr_a
// FETCH_B | reading B operand at ptr_b, pair becomes valid next cycle
// PRESENT | pair offered to the ALU, held until ready_i
// DONE    | one-cycle completion pulse, start_i still ignored

module rom_operand_fetch #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  input  logic [AW-1:0] count_i,
`ifdef ROM_FETCH_STRIDE_EN
  input  logic [AW-1:0] stride_i,
`endif
  output logic [AW-1:0] rom_dir_o,
  input  logic [DW-1:0] rom_dato_i,
  output logic [DW-1:0] op_a_o,
  output logic [DW-1:0] op_b_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] ptr_a;
  logic [AW-1:0] ptr_b;
  logic [AW:0]   remaining;
  logic [AW-1:0] step;
  logic          handshake;

  localparam logic [AW:0] REM_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] REM_FULL = {1'b1, {AW{1'b0}}};

`ifdef ROM_FETCH_STRIDE_EN
  logic [AW-1:0] stride;
  assign step = stride;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stride <= '0;
    end else if (state == IDLE && start_i) begin
      stride <= stride_i;
    end
  end
`else
  assign step = {{(AW-1){1'b0}}, 1'b1};
`endif

  assign handshake = (state == PRESENT) && valid_o && ready_i;
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    rom_dir_o = '0;
    case (state)
      IDLE: begin
        if (start_i) state_nx = FETCH_A;
      end
      FETCH_A: begin
        rom_dir_o = ptr_a;
        state_nx  = FETCH_B;
      end
      FETCH_B: begin
        rom_dir_o = ptr_b;
        state_nx  = PRESENT;
      end
      PRESENT: begin
        // Address stays on ptr_b while the ALU applies backpressure.
        rom_dir_o = ptr_b;
        if (handshake) begin
          state_nx = (remaining == REM_ONE) ? DONE : FETCH_A;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_a     <= '0;
      ptr_b     <= '0;
      remaining <= '0;
      op_a_o    <= '0;
      op_b_o    <= '0;
      valid_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            ptr_a     <= addr_a_i;
            ptr_b     <= addr_b_i;
            remaining <= (count_i == '0) ? REM_FULL : {1'b0, count_i};
          end
        end
        FETCH_A: begin
          op_a_o <= rom_dato_i;
        end
        FETCH_B: begin
          op_b_o  <= rom_dato_i;
          valid_o <= 1'b1;
        end
        PRESENT: begin
          if (handshake) begin
            valid_o   <= 1'b0;
            ptr_a     <= ptr_a + step;
            ptr_b     <= ptr_b + step;
            remaining <= remaining - REM_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_operand_fetch.sv
// Testbench for rom_operand_fetch: table-driven runs, hand-written corner
// sequences (latency, backpressure, async reset) and randomized runs checked
// against a pair-sequence model computed from the ROM contents.

module tb_rom_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [AW-1:0] count;
  logic [AW-1:0] stride;
  logic [AW-1:0] rom_dir;
  logic [DW-1:0] rom_dato;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] rom [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rom_dato = rom[rom_dir];

  rom_operand_fetch #(.DW(DW), .AW(AW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .addr_a_i   (addr_a),
    .addr_b_i   (addr_b),
    .count_i    (count),
`ifdef ROM_FETCH_STRIDE_EN
    .stride_i   (stride),
`endif
    .rom_dir_o  (rom_dir),
    .rom_dato_i (rom_dato),
    .op_a_o     (op_a),
    .op_b_o     (op_b),
    .valid_o    (valid),
    .ready_i    (ready),
    .busy_o     (busy),
    .done_o     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete run. Each accepted pair is compared with the ROM entries the
  // two address streams should reach; first/last pair and count are returned.
  task automatic do_run(input logic [3:0] a, input logic [3:0] b, input logic [3:0] cnt,
                        input logic [3:0] strd, input bit rnd,
                        output int n, output logic [31:0] fa, output logic [31:0] fb,
                        output logic [31:0] la, output logic [31:0] lb);
    int exp_n;
    bit seen_done;
    bit pv;
    bit pr;
    logic [31:0] pa;
    logic [31:0] pb;
    int ia;
    int ib;
    n = 0; fa = '0; fb = '0; la = '0; lb = '0;
    exp_n = (cnt == 0) ? 16 : int'(cnt);
    seen_done = 1'b0;
    pv = 1'b0; pr = 1'b1; pa = '0; pb = '0;
    addr_a = a; addr_b = b; count = cnt; stride = strd;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    step_cycle();
    start  = 1'b0;
    addr_a = 4'($urandom);
    addr_b = 4'($urandom);
    count  = 4'($urandom);
    stride = 4'($urandom);
    chk("run_busy_after_start", 32'(busy), 32'd1);
    for (int c = 0; c < 400 && !seen_done; c++) begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_op_a", op_a, pa);
        chk("hold_op_b", op_b, pb);
      end
      if (done) begin
        seen_done = 1'b1;
        chk("pair_count", 32'(n), 32'(exp_n));
        chk("done_valid_low", 32'(valid), 32'd0);
        start = 1'b1;
        step_cycle();
        start = 1'b0;
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
      end else begin
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rnd) start = ($urandom_range(0, 3) == 0);
        if (valid && ready) begin
          ia = (int'(a) + n * int'(strd)) % 16;
          ib = (int'(b) + n * int'(strd)) % 16;
          chk("pair_op_a", op_a, rom[ia]);
          chk("pair_op_b", op_b, rom[ib]);
          if (n == 0) begin
            fa = op_a; fb = op_b;
          end
          la = op_a; lb = op_b;
          n++;
        end
        pv = valid; pr = ready; pa = op_a; pb = op_b;
        step_cycle();
      end
    end
    if (!seen_done) begin
      tests++;
      fails++;
      $display("FAIL run_timeout actual=no_done required=done_within_400_cycles");
    end
    start = 1'b0;
    ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  cnt;
    int          n;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] la;
    logic [31:0] lb;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int          n;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] la;
    logic [31:0] lb;
    logic [3:0]  rs;

    for (int i = 0; i < 16; i++) rom[i] = 32'hA5A50000 | 32'(i);
    rom[0]  = 32'h00000001;
    rom[1]  = 32'h777abcfe;
    rom[2]  = 32'h48151623;
    rom[15] = 32'hffffffff;

    vecs[0] = '{"single", 4'd0, 4'd1, 4'd1, 1, 32'h00000001, 32'h777abcfe, 32'h00000001, 32'h777abcfe};
    vecs[1] = '{"wrap", 4'd15, 4'd15, 4'd2, 2, 32'hffffffff, 32'hffffffff, 32'h00000001, 32'h00000001};
    vecs[2] = '{"count16", 4'd3, 4'd7, 4'd0, 16, 32'hA5A50003, 32'hA5A50007, 32'h48151623, 32'hA5A50006};

    rst = 1'b1; start = 1'b0; ready = 1'b0;
    addr_a = '0; addr_b = '0; count = '0; stride = '0;
    #12;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rom_dir", 32'(rom_dir), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    #3 rst = 1'b0;
    step_cycle();

    // Latency of a single pair.
    addr_a = 4'd0; addr_b = 4'd1; count = 4'd1; ready = 1'b1; start = 1'b1;
    step_cycle();
    start = 1'b0;
    chk("lat_fa_dir", 32'(rom_dir), 32'd0);
    chk("lat_fa_valid", 32'(valid), 32'd0);
    chk("lat_fa_busy", 32'(busy), 32'd1);
    step_cycle();
    chk("lat_fb_dir", 32'(rom_dir), 32'd1);
    chk("lat_fb_valid", 32'(valid), 32'd0);
    step_cycle();
    chk("lat_valid", 32'(valid), 32'd1);
    chk("lat_op_a", op_a, 32'h00000001);
    chk("lat_op_b", op_b, 32'h777abcfe);
    step_cycle();
    chk("lat_done", 32'(done), 32'd1);
    chk("lat_done_busy", 32'(busy), 32'd1);
    chk("lat_done_valid", 32'(valid), 32'd0);
    step_cycle();
    chk("lat_done_off", 32'(done), 32'd0);
    chk("lat_idle", 32'(busy), 32'd0);
    ready = 1'b0;
    step_cycle();

    // Table-driven runs with ready tied high.
    for (int i = 0; i < 3; i++) begin
      do_run(vecs[i].a, vecs[i].b, vecs[i].cnt, 4'd1, 1'b0, n, fa, fb, la, lb);
      chk({vecs[i].name, "_n"}, 32'(n), 32'(vecs[i].n));
      chk({vecs[i].name, "_first_a"}, fa, vecs[i].fa);
      chk({vecs[i].name, "_first_b"}, fb, vecs[i].fb);
      chk({vecs[i].name, "_last_a"}, la, vecs[i].la);
      chk({vecs[i].name, "_last_b"}, lb, vecs[i].lb);
      step_cycle();
    end

    // Backpressure: pair held for 5 cycles, no pointer advance.
    addr_a = 4'd2; addr_b = 4'd5; count = 4'd2; ready = 1'b0; start = 1'b1;
    step_cycle();
    start = 1'b0;
    step_cycle();
    step_cycle();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_op_a", op_a, 32'h48151623);
      chk("bp_op_b", op_b, 32'hA5A50005);
      chk("bp_rom_dir", 32'(rom_dir), 32'd5);
      step_cycle();
    end
    ready = 1'b1;
    step_cycle();
    chk("bp_adv_a_dir", 32'(rom_dir), 32'd3);
    chk("bp_adv_valid", 32'(valid), 32'd0);
    step_cycle();
    chk("bp_adv_b_dir", 32'(rom_dir), 32'd6);
    step_cycle();
    chk("bp_pair2_a", op_a, 32'hA5A50003);
    chk("bp_pair2_b", op_b, 32'hA5A50006);
    step_cycle();
    chk("bp_done", 32'(done), 32'd1);
    ready = 1'b0;
    step_cycle();

    // Asynchronous reset in the middle of FETCH_A.
    addr_a = 4'd1; addr_b = 4'd2; count = 4'd3; ready = 1'b1; start = 1'b1;
    step_cycle();
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_rom_dir", 32'(rom_dir), 32'd0);
    chk("arst_op_a", op_a, 32'd0);
    chk("arst_op_b", op_b, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      chk("arst_no_done", 32'(done), 32'd0);
      chk("arst_stays_idle", 32'(busy), 32'd0);
    end
    do_run(4'd2, 4'd0, 4'd1, 4'd1, 1'b0, n, fa, fb, la, lb);
    chk("post_rst_op_a", fa, 32'h48151623);
    chk("post_rst_op_b", fb, 32'h00000001);
    step_cycle();

`ifdef ROM_FETCH_STRIDE_EN
    do_run(4'd0, 4'd1, 4'd2, 4'd2, 1'b0, n, fa, fb, la, lb);
    chk("stride_n", 32'(n), 32'd2);
    chk("stride_first_a", fa, 32'h00000001);
    chk("stride_first_b", fb, 32'h777abcfe);
    chk("stride_last_a", la, 32'h48151623);
    chk("stride_last_b", lb, 32'hA5A50003);
    step_cycle();
`endif

    // Randomized runs with random backpressure and stray start pulses.
    for (int r = 0; r < 10; r++) begin
`ifdef ROM_FETCH_STRIDE_EN
      rs = 4'($urandom);
`else
      rs = 4'd1;
`endif
      do_run(4'($urandom), 4'($urandom), 4'($urandom_range(0, 6)), rs, 1'b1, n, fa, fb, la, lb);
      step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rom_operand_fetch.md
Name: rom_operand_fetch

Overview:
- Sequencer directly upstream of the ALU and directly downstream of the team's 16x32 constant ROM.
- Drives the ROM address (rom_dir_o) and captures the returned 32-bit data.
- Assembles operand pairs (A, B) from two independent address streams.
- Presents each pair to the ALU with a valid/ready handshake; after a single start pulse, fetches a programmable number of pairs.

Parameters:
- DW, 32, operand / ROM data width.
- AW, 4, ROM address width (16 entries).

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  begin a fetch run; sampled only in IDLE.
- addr_a_i  input  AW  first ROM address of the A stream.
- addr_b_i  input  AW  first ROM address of the B stream.
- count_i  input  AW  number of pairs to fetch; 0 means 16.
- rom_dir_o  output  AW  address to the ROM (ROM is combinational, data valid same cycle).
- rom_dato_i  input  DW  data returned by the ROM.
- op_a_o  output  DW  registered operand A.
- op_b_o  output  DW  registered operand B.
- valid_o  output  1  op_a_o/op_b_o hold a valid pair.
- ready_i  input  1  ALU accepts the pair.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse after the last pair is accepted.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, rom_dir_o=0, op_a_o=0, op_b_o=0, valid_o=0, busy_o=0, done_o=0, all internal pointers/counters=0.
- Reset asserted mid-run aborts immediately to these values; no pair is delivered and done_o is not pulsed.
- Internal registers: ptr_a, ptr_b (AW bits each), remaining (AW+1 bits).

State machine:
- IDLE: rom_dir_o=0. On start_i=1, latch ptr_a=addr_a_i, ptr_b=addr_b_i, remaining=(count_i==0 ? 16 : count_i), then go to FETCH_A.
- FETCH_A: rom_dir_o=ptr_a. On the clock edge, op_a_o<=rom_dato_i; go to FETCH_B.
- FETCH_B: rom_dir_o=ptr_b. On the clock edge, op_b_o<=rom_dato_i, valid_o<=1; go to PRESENT.
- PRESENT: valid_o=1, and op_a_o/op_b_o held stable while ready_i=0.
  - Handshake is valid_o & ready_i at a rising edge. On handshake: valid_o<=0, ptr_a<=ptr_a+1, ptr_b<=ptr_b+1 (mod 16, 15 wraps to 0), remaining<=remaining-1.
  - If remaining was 1, go to DONE; otherwise go to FETCH_A.
- DONE: done_o=1 for exactly one cycle, busy_o still 1; then go to IDLE.

Timing and handshake rules:
- Latency: start_i sampled at edge k gives FETCH_A in cycle k+1, FETCH_B in k+2, and valid_o=1 from cycle k+3.
- Steady-state throughput with ready_i tied high: one pair per 3 cycles.
- ready_i may be high before valid_o; it has no effect outside PRESENT.
- start_i is ignored while busy_o=1, including when it is asserted in the DONE cycle.
- A new start_i is accepted in the cycle after DONE (IDLE).
- op_a_o/op_b_o keep their last values after the run; valid_o qualifies them.
- A stream and B stream may use the same address; no conflict arises because fetches are sequential.
- Inputs addr_a_i, addr_b_i and count_i are ignored after the start cycle.

Optional Feature:
- Macro: ROM_FETCH_STRIDE_EN.
- Defined: adds port stride_i (input, AW bits), latched with start_i. On each handshake the pointers advance by the latched stride, mod 16. Stride 0 re-reads the same entries every pair.
- Undefined: the port is absent and the pointers advance by 1.
- All other behaviour is identical in both builds.

Test Plan:
Bench ROM contents: entry 0=32'h00000001, 1=32'h777abcfe, 2=32'h48151623, 15=32'hffffffff.
- Single pair: addr_a_i=0, addr_b_i=1, count_i=1, ready_i=1, pulse start_i -> valid_o=1 exactly 3 cycles after start with op_a_o=32'h00000001 and op_b_o=32'h777abcfe; done_o pulses the next cycle; busy_o returns to 0.
- Wrap-around: addr_a_i=15, addr_b_i=15, count_i=2 -> pairs (ffffffff, ffffffff) then (00000001, 00000001).
- Backpressure: count_i=2, hold ready_i=0 for 5 cycles in PRESENT -> valid_o and operands stay stable, rom_dir_o stays at ptr_b, and no pointer advance until ready_i=1.
- count_i=0 -> exactly 16 handshakes, then a single done_o pulse; start_i asserted mid-run is ignored.
- Async reset asserted between FETCH_A and FETCH_B (not on a clock edge) -> all outputs 0 immediately; no done_o. A subsequent start with addr_a_i=2, addr_b_i=0, count_i=1 yields op_a_o=32'h48151623, op_b_o=32'h00000001.
- With ROM_FETCH_STRIDE_EN defined and stride_i=2: addr_a_i=0, addr_b_i=1, count_i=2 -> pairs (entry0, entry1) then (entry2, entry3), i.e. op_a_o=32'h48151623 on the second pair.
